// File: rtl/axi_slave_ram.sv
// axi_slave_ram -- AXI4 memory-mapped responder backed by an on-chip RAM.
// Serves one INCR burst at a time (write or read). Burst type and size are
// ignored: every beat is full width, and the word index wraps within the RAM.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   s_axi_aw*           write address channel (id, addr, len, valid/ready)
//   s_axi_w*            write data channel (data, strb, last, valid/ready)
//   s_axi_b*            write response channel (id, resp, valid/ready)
//   s_axi_ar*           read address channel (id, addr, len, valid/ready)
//   s_axi_r*            read data channel (id, data, resp, last, valid/ready)
//
// Optional feature: define AXI_SLV_ERR_CHK_EN to decode the address window
// (DECERR outside C_BASE_ADDR's window, RAM writes suppressed, rdata zeroed)
// and to flag misplaced or missing wlast with SLVERR. Without it, upper
// address bits alias, wlast is ignored and every response is OKAY.
module axi_slave_ram #(
    parameter int C_S_AXI_ID_WIDTH   = 1,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_MEM_AW           = 10,
    parameter logic [C_S_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR = 32'h0100_0000
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [C_S_AXI_ID_WIDTH-1:0]     s_axi_awid,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [7:0]                      s_axi_awlen,
    input  logic                            s_axi_awvalid,
    output logic                            s_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                            s_axi_wlast,
    input  logic                            s_axi_wvalid,
    output logic                            s_axi_wready,
    output logic [C_S_AXI_ID_WIDTH-1:0]     s_axi_bid,
    output logic [1:0]                      s_axi_bresp,
    output logic                            s_axi_bvalid,
    input  logic                            s_axi_bready,
    input  logic [C_S_AXI_ID_WIDTH-1:0]     s_axi_arid,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [7:0]                      s_axi_arlen,
    input  logic                            s_axi_arvalid,
    output logic                            s_axi_arready,
    output logic [C_S_AXI_ID_WIDTH-1:0]     s_axi_rid,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                      s_axi_rresp,
    output logic                            s_axi_rlast,
    output logic                            s_axi_rvalid,
    input  logic                            s_axi_rready
);

    localparam int ADDR_LSB = $clog2(C_S_AXI_DATA_WIDTH / 8);
    localparam int STRB_W   = C_S_AXI_DATA_WIDTH / 8;
    localparam logic [C_MEM_AW-1:0] IDX_ONE = 1;

    typedef enum logic [1:0] {IDLE, WDATA, WRESP, RDATA} state_t;

    state_t                          state, state_nxt;
    logic [C_S_AXI_DATA_WIDTH-1:0]   mem [0:(2**C_MEM_AW)-1];
    logic [C_MEM_AW-1:0]             idx;
    logic [7:0]                      cnt, len;
    logic [C_S_AXI_ID_WIDTH-1:0]     id;
    logic                            aw_hs, ar_hs, w_hs, r_hs, last_beat;
    logic                            wr_en, rd_zero;
    logic [C_MEM_AW-1:0]             aw_idx, ar_idx;
    logic                            unused_bits;

    assign aw_idx    = s_axi_awaddr[C_MEM_AW+ADDR_LSB-1:ADDR_LSB];
    assign ar_idx    = s_axi_araddr[C_MEM_AW+ADDR_LSB-1:ADDR_LSB];
    assign aw_hs     = s_axi_awvalid && s_axi_awready;
    assign ar_hs     = s_axi_arvalid && s_axi_arready;
    assign w_hs      = s_axi_wvalid && s_axi_wready;
    assign r_hs      = s_axi_rvalid && s_axi_rready;
    assign last_beat = (cnt == len);

    // Address bits outside the index (and wlast, base) only matter with error checking.
    assign unused_bits = ^{s_axi_awaddr, s_axi_araddr, s_axi_wlast, C_BASE_ADDR};

`ifdef AXI_SLV_ERR_CHK_EN
    logic dec_err, slv_err, aw_dec, ar_dec;

    assign aw_dec = s_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:C_MEM_AW+ADDR_LSB]
                 != C_BASE_ADDR[C_S_AXI_ADDR_WIDTH-1:C_MEM_AW+ADDR_LSB];
    assign ar_dec = s_axi_araddr[C_S_AXI_ADDR_WIDTH-1:C_MEM_AW+ADDR_LSB]
                 != C_BASE_ADDR[C_S_AXI_ADDR_WIDTH-1:C_MEM_AW+ADDR_LSB];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_err <= 1'b0;
            slv_err <= 1'b0;
        end else if (aw_hs) begin
            dec_err <= aw_dec;
            slv_err <= 1'b0;
        end else if (ar_hs) begin
            dec_err <= ar_dec;
        end else if (w_hs && (s_axi_wlast != last_beat)) begin
            slv_err <= 1'b1;
        end
    end

    // The first read word is fetched on the AR edge, before dec_err is latched.
    assign rd_zero     = (state == IDLE) ? ar_dec : dec_err;
    assign wr_en       = !dec_err;
    assign s_axi_bresp = dec_err ? 2'b11 : (slv_err ? 2'b10 : 2'b00);
    assign s_axi_rresp = dec_err ? 2'b11 : 2'b00;
`else
    assign rd_zero     = 1'b0;
    assign wr_en       = 1'b1;
    assign s_axi_bresp = 2'b00;
    assign s_axi_rresp = 2'b00;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            cnt         <= '0;
            len         <= '0;
            id          <= '0;
            s_axi_rdata <= '0;
        end else begin
            state <= state_nxt;
            if (aw_hs) begin
                id  <= s_axi_awid;
                idx <= aw_idx;
                len <= s_axi_awlen;
                cnt <= '0;
            end else if (ar_hs) begin
                id          <= s_axi_arid;
                idx         <= ar_idx;
                len         <= s_axi_arlen;
                cnt         <= '0;
                s_axi_rdata <= rd_zero ? '0 : mem[ar_idx];
            end else if (w_hs) begin
                cnt <= cnt + 8'd1;
                idx <= idx + IDX_ONE;
            end else if (r_hs && !last_beat) begin
                // Prefetch the next word on the accepting edge for full-rate beats.
                cnt         <= cnt + 8'd1;
                idx         <= idx + IDX_ONE;
                s_axi_rdata <= rd_zero ? '0 : mem[idx + IDX_ONE];
            end
        end
    end

    // RAM contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_hs && wr_en) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (s_axi_wstrb[b]) mem[idx][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        s_axi_awready = 1'b0;
        s_axi_arready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_bvalid  = 1'b0;
        s_axi_rvalid  = 1'b0;
        s_axi_rlast   = 1'b0;
        s_axi_bid     = id;
        s_axi_rid     = id;
        case (state)
            IDLE: begin
                s_axi_awready = 1'b1;
                s_axi_arready = !s_axi_awvalid;   // write wins a tie
                if (s_axi_awvalid)      state_nxt = WDATA;
                else if (s_axi_arvalid) state_nxt = RDATA;
            end
            WDATA: begin
                s_axi_wready = 1'b1;
                if (s_axi_wvalid && last_beat) state_nxt = WRESP;
            end
            WRESP: begin
                s_axi_bvalid = 1'b1;
                if (s_axi_bready) state_nxt = IDLE;
            end
            RDATA: begin
                s_axi_rvalid = 1'b1;
                s_axi_rlast  = last_beat;
                if (s_axi_rready && last_beat) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_axi_slave_ram.sv
// tb_axi_slave_ram -- directed scoreboard bench for axi_slave_ram.
// Stimulus pushes expected B/R responses into queues; a negedge monitor pops
// and compares on every handshake and checks that stalled read beats hold.
module tb_axi_slave_ram;
    localparam int IDW = 1;
    localparam int AW  = 32;
    localparam int DW  = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [IDW-1:0]  awid, bid, arid, rid;
    logic [AW-1:0]   awaddr, araddr;
    logic [7:0]      awlen, arlen;
    logic            awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic            arvalid, arready, rlast, rvalid, rready;
    logic [DW-1:0]   wdata, rdata;
    logic [DW/8-1:0] wstrb;
    logic [1:0]      bresp, rresp;

    axi_slave_ram dut (
        .clk(clk), .rst_n(rst_n),
        .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen),
        .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
        .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen),
        .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
        .s_axi_rvalid(rvalid), .s_axi_rready(rready)
    );

    typedef struct {logic [IDW-1:0] id; logic [1:0] resp;} bexp_t;
    typedef struct {logic [IDW-1:0] id; logic [DW-1:0] data; logic [1:0] resp; logic last;} rexp_t;
    bexp_t bq[$];
    rexp_t rq[$];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event did not occur", name);
    endtask

    // ---------------- monitor / scoreboard ----------------
    bexp_t         be;
    rexp_t         re;
    logic          stall_q = 1'b0;
    logic [DW-1:0] stall_data;
    logic          stall_last;
    logic [IDW-1:0] stall_id;

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_q = 1'b0;
        end else begin
            if (bvalid && bready) begin
                if (bq.size() == 0) fail_now("b_unexpected");
                else begin
                    be = bq.pop_front();
                    chk("bid", bid, be.id);
                    chk("bresp", bresp, be.resp);
                end
            end
            if (stall_q && rvalid) begin
                chk("r_hold_data", rdata, stall_data);
                chk("r_hold_last", rlast, stall_last);
                chk("r_hold_id", rid, stall_id);
            end
            if (rvalid && rready) begin
                if (rq.size() == 0) fail_now("r_unexpected");
                else begin
                    re = rq.pop_front();
                    chk("rdata", rdata, re.data);
                    chk("rid", rid, re.id);
                    chk("rresp", rresp, re.resp);
                    chk("rlast", rlast, re.last);
                end
            end
            stall_q    = rvalid && !rready;
            stall_data = rdata;
            stall_last = rlast;
            stall_id   = rid;
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic rdy(input int ch);
        case (ch)
            0:       return awready;
            1:       return wready;
            default: return arready;
        endcase
    endfunction

    // Wait for ready (sampled at negedge), then step past the handshake edge.
    task automatic hs(input int ch, input string name);
        int n = 0;
        @(negedge clk);
        while (!rdy(ch) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!rdy(ch)) fail_now(name);
        @(posedge clk);
        #1;
    endtask

    task automatic wr_burst(input logic [AW-1:0] addr, input logic [7:0] len,
                            input logic [IDW-1:0] id, input logic [DW-1:0] d0,
                            input logic [DW/8-1:0] strb, input logic [1:0] resp,
                            input int wlast_beat);
        int n = 0;
        bq.push_back('{id, resp});
        awaddr = addr; awlen = len; awid = id; awvalid = 1'b1;
        hs(0, "aw_timeout");
        awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            wdata = d0 + DW'(i); wstrb = strb; wlast = (i == wlast_beat); wvalid = 1'b1;
            hs(1, "w_timeout");
        end
        wvalid = 1'b0; wlast = 1'b0;
        @(negedge clk);
        chk("bvalid_latency", bvalid, 1'b1);
        while (bq.size() > 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (bq.size() > 0) fail_now("b_timeout");
        @(posedge clk);
        #1;
    endtask

    task automatic rd_burst(input logic [AW-1:0] addr, input logic [7:0] len,
                            input logic [IDW-1:0] id, input logic [DW-1:0] d0,
                            input logic [DW-1:0] inc, input logic [1:0] resp,
                            input bit toggle);
        int n = 0;
        for (int i = 0; i <= int'(len); i++)
            rq.push_back('{id, d0 + inc * DW'(i), resp, i == int'(len)});
        araddr = addr; arlen = len; arid = id; arvalid = 1'b1;
        hs(2, "ar_timeout");
        arvalid = 1'b0;
        rready  = 1'b1;
        @(negedge clk);
        chk("rvalid_latency", rvalid, 1'b1);
        while (rq.size() > 0 && n < 600) begin
            @(posedge clk);
            #1;
            if (toggle) rready = ~rready;
            n++;
        end
        if (rq.size() > 0) fail_now("r_timeout");
        @(posedge clk);
        #1;
        rready = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        awid = '0; awaddr = '0; awlen = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b1;
        arid = '0; araddr = '0; arlen = '0; arvalid = 1'b0; rready = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_awready", awready, 1'b1);
        chk("rst_arready", arready, 1'b1);
        chk("rst_wready", wready, 1'b0);
        chk("rst_bvalid", bvalid, 1'b0);
        chk("rst_rvalid", rvalid, 1'b0);
        chk("rst_rlast", rlast, 1'b0);
        chk("rst_rdata", rdata, 32'h0);
        awvalid = 1'b1;
        #1;
        chk("rst_arready_awv", arready, 1'b0);
        awvalid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1/2/3: 16-beat write, full-rate read, throttled read
        wr_burst(32'h0100_0000, 8'd15, 1'b1, 32'd0, 4'hF, 2'b00, 15);
        rd_burst(32'h0100_0000, 8'd15, 1'b1, 32'd0, 32'd1, 2'b00, 1'b0);
        rd_burst(32'h0100_0000, 8'd15, 1'b1, 32'd0, 32'd1, 2'b00, 1'b1);

        // Index wrap: last word then word 0
        wr_burst(32'h0100_0FFC, 8'd1, 1'b0, 32'hA0, 4'hF, 2'b00, 1);
        rd_burst(32'h0100_0FFC, 8'd1, 1'b0, 32'hA0, 32'd1, 2'b00, 1'b0);

        // 4: simultaneous AW/AR, write wins, AR blocked until B handshake
        bready = 1'b0;
        awaddr = 32'h0100_0040; awlen = 8'd0; awid = 1'b0; awvalid = 1'b1;
        araddr = 32'h0100_0040; arlen = 8'd0; arid = 1'b1; arvalid = 1'b1;
        @(negedge clk);
        chk("t4_awready", awready, 1'b1);
        chk("t4_arready", arready, 1'b0);
        @(posedge clk); #1;
        awvalid = 1'b0;
        wdata = 32'h55; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
        @(negedge clk);
        chk("t4_arready_wdata", arready, 1'b0);
        @(posedge clk); #1;
        wvalid = 1'b0; wlast = 1'b0;
        @(negedge clk);
        chk("t4_bvalid", bvalid, 1'b1);
        chk("t4_arready_wresp", arready, 1'b0);
        @(negedge clk);
        chk("t4_arready_wresp2", arready, 1'b0);
        bq.push_back('{1'b0, 2'b00});
        @(posedge clk); #1;
        bready = 1'b1;
        rd_burst(32'h0100_0040, 8'd0, 1'b1, 32'h55, 32'd0, 2'b00, 1'b0);
        chk("t4_bq_empty", bq.size(), 0);

        // 5: partial strobe bytes 0 and 2
        wr_burst(32'h0100_0080, 8'd0, 1'b0, 32'h1122_3344, 4'hF, 2'b00, 0);
        wr_burst(32'h0100_0080, 8'd0, 1'b0, 32'hAABB_CCDD, 4'b0101, 2'b00, 0);
        rd_burst(32'h0100_0080, 8'd0, 1'b0, 32'h11BB_33DD, 32'd0, 2'b00, 1'b0);

        // Reset mid-burst: two beats land, burst abandoned
        awaddr = 32'h0100_0100; awlen = 8'd3; awid = 1'b0; awvalid = 1'b1;
        hs(0, "aw_timeout");
        awvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            wdata = 32'h77 + 32'(i); wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
            hs(1, "w_timeout");
        end
        wvalid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_awready", awready, 1'b1);
        chk("mid_rst_wready", wready, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        rd_burst(32'h0100_0100, 8'd1, 1'b0, 32'h77, 32'd1, 2'b00, 1'b0);

`ifdef AXI_SLV_ERR_CHK_EN
        // Out-of-window write: DECERR, word 0 (0xA1) untouched
        wr_burst(32'h0200_0000, 8'd0, 1'b1, 32'hDEAD, 4'hF, 2'b11, 0);
        rd_burst(32'h0100_0000, 8'd0, 1'b0, 32'hA1, 32'd0, 2'b00, 1'b0);
        rd_burst(32'h0200_0000, 8'd1, 1'b1, 32'd0, 32'd0, 2'b11, 1'b0);
        // Early wlast on beat 2 of 4
        wr_burst(32'h0100_0200, 8'd3, 1'b0, 32'h30, 4'hF, 2'b10, 2);
`else
        // Upper bits alias onto word 0; wlast placement is ignored
        wr_burst(32'h0200_0000, 8'd0, 1'b1, 32'hBEEF, 4'hF, 2'b00, 0);
        rd_burst(32'h0100_0000, 8'd0, 1'b0, 32'hBEEF, 32'd0, 2'b00, 1'b0);
        wr_burst(32'h0100_0200, 8'd3, 1'b0, 32'h30, 4'hF, 2'b00, 2);
`endif
        rd_burst(32'h0100_0200, 8'd3, 1'b0, 32'h30, 32'd1, 2'b00, 1'b1);

        chk("final_bq_empty", bq.size(), 0);
        chk("final_rq_empty", rq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
